mac_pipe: RTL and testbench

- Parametrised two-stage unsigned multiply-add/accumulate pipeline with valid/ready handshakes on input and output.
- Stage 1 registers the product A*B, operand C and the mode. Stage 2 forms the result: add C, accumulate, pass the product, or load.
- Saturating or wrapping output with a sticky overflow flag.
- Sits between operand sources and downstream consumers in the datapath labs.

---
 rtl/mac_pipe.sv | 146 ++++++++++++++
 tb/tb_mac_pipe.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_pipe.sv
// ---------------------------------------------------------------------------
// mac_pipe -- two-stage unsigned multiply-add / accumulate pipeline
//
// Stage 1 registers the full-precision product A*B together with C and the
// mode. Stage 2 forms A*B+C, acc+A*B or A*B into the result register, which
// doubles as the accumulator. Overflow either saturates (SAT=1) or wraps
// (SAT=0) and always sets a sticky flag.
//
// Ports
//   clk_n      in   1      clock, rising edge active
//   reset_n    in   1      asynchronous reset, active high
//   in_valid   in   1      operand beat present
//   in_ready   out  1      a beat is accepted this cycle
//   A          in   A_W    multiplicand
//   B          in   B_W    multiplier
//   C          in   C_W    addend
//   mode       in   2      00 A*B+C, 01 acc+A*B, 10 A*B, 11 A*B+C (restart)
//   out_valid  out  1      result holds valid data
//   out_ready  in   1      downstream accepts result
//   result     out  OUT_W  result register / accumulator
//   overflow   out  1      sticky overflow flag
//   ovf_clr    in   1      synchronous clear of overflow (a new overflow wins)
// ---------------------------------------------------------------------------
module mac_pipe #(
   parameter int A_W   = 7,
   parameter int B_W   = 7,
   parameter int C_W   = 14,
   parameter int OUT_W = 15,
   parameter int SAT   = 1
) (
   input  logic             clk_n,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [A_W-1:0]   A,
   input  logic [B_W-1:0]   B,
   input  logic [C_W-1:0]   C,
   input  logic [1:0]       mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] result,
   output logic             overflow,
   input  logic             ovf_clr
);

   localparam int PROD_W = A_W + B_W;

   // The sum is OUT_W+1 bits wide; a narrower OUT_W could lose product or
   // addend bits before the overflow test ever sees them.
   generate
      if ((OUT_W < PROD_W) || (OUT_W < C_W)) begin : g_bad_out_w
         $error("mac_pipe: OUT_W must be >= max(A_W+B_W, C_W)");
      end
   endgenerate

   typedef enum logic [1:0] {
      MODE_ADD = 2'b00,
      MODE_ACC = 2'b01,
      MODE_MUL = 2'b10,
      MODE_RST = 2'b11
   } mode_e;

   function automatic logic [OUT_W-1:0] sat_fn(input logic [OUT_W:0] s);
      if (s[OUT_W] && (SAT != 0)) begin
         return '1;
      end
      return s[OUT_W-1:0];
   endfunction

   logic              w_xfer_p0;
   logic [PROD_W-1:0] w_prod_p0;
   logic              w_fire_p2;

   logic              r_vld_p1;
   logic [PROD_W-1:0] r_prod_p1;
   logic [C_W-1:0]    r_c_p1;
   mode_e             r_mode_p1;

   logic [OUT_W:0]    w_prod_x;
   logic [OUT_W:0]    w_c_x;
   logic [OUT_W:0]    w_sum;

   logic              r_vld_p2;
   logic [OUT_W-1:0]  r_result_p2;
   logic              r_ovf;

   // in_ready depends on out_ready through the stage-2 fire term only;
   // in_valid never feeds back into it.
   assign w_fire_p2 = r_vld_p1 & (~r_vld_p2 | out_ready);
   assign in_ready  = ~r_vld_p1 | w_fire_p2;
   assign w_xfer_p0 = in_valid & in_ready;
   assign w_prod_p0 = PROD_W'(A) * PROD_W'(B);

   // ---- stage 1: product, addend and mode ----
   always_ff @(posedge clk_n) begin
      if (w_xfer_p0) begin
         r_prod_p1 <= w_prod_p0;
         r_c_p1    <= C;
         r_mode_p1 <= mode_e'(mode);
      end
   end

   // ---- stage 2: sum selection ----
   assign w_prod_x = (OUT_W+1)'(r_prod_p1);
   assign w_c_x    = (OUT_W+1)'(r_c_p1);

   always_comb begin
      w_sum = w_prod_x;
      case (r_mode_p1)
         MODE_ACC: w_sum = {1'b0, r_result_p2} + w_prod_x;
         MODE_MUL: w_sum = w_prod_x;
         default:  w_sum = w_prod_x + w_c_x;
      endcase
   end

   // Result is reset together with the control state because it is also
   // the accumulator: an accumulate after reset must start from zero.
   always_ff @(posedge clk_n or posedge reset_n) begin
      if (reset_n) begin
         r_vld_p1    <= 1'b0;
         r_vld_p2    <= 1'b0;
         r_result_p2 <= '0;
         r_ovf       <= 1'b0;
      end else begin
         if (in_ready) begin
            r_vld_p1 <= in_valid;
         end
         if (w_fire_p2) begin
            r_vld_p2    <= 1'b1;
            r_result_p2 <= sat_fn(w_sum);
         end else if (out_ready) begin
            r_vld_p2    <= 1'b0;
         end
         if (w_fire_p2 && w_sum[OUT_W]) begin
            r_ovf <= 1'b1;
         end else if (ovf_clr) begin
            r_ovf <= 1'b0;
         end
      end
   end

   assign out_valid = r_vld_p2;
   assign result    = r_result_p2;
   assign overflow  = r_ovf;

endmodule

// File: tb/tb_mac_pipe.sv
// ---------------------------------------------------------------------------
// tb_mac_pipe -- drives one saturating and one wrapping mac_pipe with the
// same stimulus; a scoreboard queue carries expected results for both.
// ---------------------------------------------------------------------------
module tb_mac_pipe;

   localparam int unsigned MAXV = 32767;

   logic        clk_n = 1'b0;
   logic        reset_n = 1'b1;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b1;
   logic        ovf_clr = 1'b0;
   logic [6:0]  A = '0;
   logic [6:0]  B = '0;
   logic [13:0] C = '0;
   logic [1:0]  mode = '0;

   logic        in_ready_s, in_ready_w;
   logic        out_valid_s, out_valid_w;
   logic [14:0] result_s, result_w;
   logic        overflow_s, overflow_w;

   mac_pipe #(.A_W(7), .B_W(7), .C_W(14), .OUT_W(15), .SAT(1)) u_sat (
      .clk_n(clk_n), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready_s),
      .A(A), .B(B), .C(C), .mode(mode), .out_valid(out_valid_s), .out_ready(out_ready),
      .result(result_s), .overflow(overflow_s), .ovf_clr(ovf_clr)
   );

   mac_pipe #(.A_W(7), .B_W(7), .C_W(14), .OUT_W(15), .SAT(0)) u_wrap (
      .clk_n(clk_n), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready_w),
      .A(A), .B(B), .C(C), .mode(mode), .out_valid(out_valid_w), .out_ready(out_ready),
      .result(result_w), .overflow(overflow_w), .ovf_clr(ovf_clr)
   );

   always #5 clk_n = ~clk_n;

   typedef struct {
      logic [14:0] rs;
      logic [14:0] rw;
      logic        os;
      logic        ow;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   failures = 0;
   int   pushes = 0;
   int   pops = 0;
   int   stalls = 0;
   bit   rnd = 1'b0;

   int unsigned acc_s = 0, acc_w = 0;
   logic        fl_s = 1'b0, fl_w = 1'b0;
   exp_t        e_mon;
   int unsigned p_mon, raw_s, raw_w;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Scoreboard: pop/compare on output transfers, model and push on input
   // transfers. Sampled on the falling edge, away from the active edge.
   always @(negedge clk_n) begin
      if (reset_n) begin
         q.delete();
         acc_s = 0;
         acc_w = 0;
         fl_s  = 1'b0;
         fl_w  = 1'b0;
      end else begin
         if (out_valid_s && out_ready) begin
            if (q.size() == 0) begin
               chk("spurious_out", {31'd0, out_valid_s}, 32'd0);
            end else begin
               e_mon = q.pop_front();
               fl_s  = fl_s | e_mon.os;
               fl_w  = fl_w | e_mon.ow;
               pops++;
               chk("res_sat", {17'd0, result_s}, {17'd0, e_mon.rs});
               chk("res_wrap", {17'd0, result_w}, {17'd0, e_mon.rw});
               chk("ovf_sat", {31'd0, overflow_s}, {31'd0, fl_s});
               chk("ovf_wrap", {31'd0, overflow_w}, {31'd0, fl_w});
            end
         end
         if (ovf_clr) begin
            fl_s = 1'b0;
            fl_w = 1'b0;
         end
         if (in_valid && in_ready_s) begin
            p_mon = int'(A) * int'(B);
            case (mode)
               2'b01:   begin raw_s = acc_s + p_mon; raw_w = acc_w + p_mon; end
               2'b10:   begin raw_s = p_mon; raw_w = p_mon; end
               default: begin raw_s = p_mon + int'(C); raw_w = raw_s; end
            endcase
            e_mon.os = (raw_s > MAXV);
            e_mon.ow = (raw_w > MAXV);
            e_mon.rs = e_mon.os ? 15'h7fff : raw_s[14:0];
            e_mon.rw = raw_w[14:0];
            acc_s = {17'd0, e_mon.rs};
            acc_w = {17'd0, e_mon.rw};
            q.push_back(e_mon);
            pushes++;
         end
      end
   end

   // Present one beat and return just after the edge that accepted it.
   task automatic send(input logic [6:0] a, input logic [6:0] b,
                       input logic [13:0] c, input logic [1:0] m);
      bit got;
      int n;
      A = a; B = b; C = c; mode = m;
      in_valid = 1'b1;
      n = 0;
      forever begin
         @(negedge clk_n);
         got = in_ready_s;
         @(posedge clk_n);
         #1;
         if (rnd) out_ready = 1'($urandom_range(0, 1));
         if (got) break;
         n++;
         stalls++;
         if (n > 300) begin
            chk("accept_timeout", n, 0);
            break;
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      for (int i = 0; i < n; i++) begin
         @(posedge clk_n);
         #1;
         if (rnd) out_ready = 1'($urandom_range(0, 1));
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      in_valid = 1'b0;
      while (q.size() != 0) begin
         @(posedge clk_n);
         #1;
         if (rnd) out_ready = 1'($urandom_range(0, 1));
         n++;
         if (n > 500) begin
            chk("drain_timeout", q.size(), 0);
            break;
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=running expected=finished");
      $fatal(1, "watchdog");
   end

   logic [14:0] held;
   int          st0;

   initial begin
      // reset state
      repeat (2) @(posedge clk_n);
      #1 reset_n = 1'b0;
      @(negedge clk_n);
      chk("rst_in_ready", {31'd0, in_ready_s}, 32'd1);
      chk("rst_out_valid", {31'd0, out_valid_s}, 32'd0);
      chk("rst_result", {17'd0, result_s}, 32'd0);
      chk("rst_overflow", {31'd0, overflow_s}, 32'd0);
      @(posedge clk_n);
      #1;

      // basic with latency
      st0 = stalls;
      send(7'd127, 7'd127, 14'd16383, 2'b00);
      chk("basic_no_stall", stalls - st0, 0);
      @(negedge clk_n);
      chk("lat_cycle1_vld", {31'd0, out_valid_s}, 32'd0);
      @(negedge clk_n);
      chk("lat_cycle2_vld", {31'd0, out_valid_s}, 32'd1);
      chk("lat_cycle2_res", {17'd0, result_s}, 32'd32512);
      @(posedge clk_n);
      #1;
      send(7'd3, 7'd5, 14'd1, 2'b10);
      drain();
      idle(2);
      chk("mul_result_held", {17'd0, result_s}, 32'd15);

      // accumulate into overflow
      send(7'd0, 7'd0, 14'd0, 2'b11);
      for (int i = 0; i < 4; i++) send(7'd100, 7'd100, 14'd0, 2'b01);
      drain();
      idle(3);
      chk("acc_sat_final", {17'd0, result_s}, 32'd32767);
      chk("acc_wrap_final", {17'd0, result_w}, 32'd7232);
      chk("acc_ovf_sat", {31'd0, overflow_s}, 32'd1);
      chk("acc_ovf_wrap", {31'd0, overflow_w}, 32'd1);
      idle(5);
      chk("ovf_sticky", {31'd0, overflow_s}, 32'd1);
      ovf_clr = 1'b1;
      @(posedge clk_n);
      #1 ovf_clr = 1'b0;
      chk("ovf_clr_sat", {31'd0, overflow_s}, 32'd0);
      chk("ovf_clr_wrap", {31'd0, overflow_w}, 32'd0);

      // backpressure
      out_ready = 1'b0;
      send(7'd1, 7'd2, 14'd3, 2'b00);
      send(7'd4, 7'd5, 14'd6, 2'b10);
      A = 7'd7; B = 7'd8; C = 14'd9; mode = 2'b01;
      in_valid = 1'b1;
      @(negedge clk_n);
      chk("bp_in_ready", {31'd0, in_ready_s}, 32'd0);
      chk("bp_out_valid", {31'd0, out_valid_s}, 32'd1);
      held = result_s;
      chk("bp_result", {17'd0, result_s}, 32'd5);
      @(negedge clk_n);
      chk("bp_in_ready2", {31'd0, in_ready_s}, 32'd0);
      chk("bp_hold", {17'd0, result_s}, {17'd0, held});
      @(posedge clk_n);
      #1 out_ready = 1'b1;
      send(7'd7, 7'd8, 14'd9, 2'b01);
      drain();
      chk("bp_count", pops, pushes);

      // streaming, no stalls expected
      st0 = stalls;
      for (int i = 0; i < 20; i++)
         send(7'($urandom), 7'($urandom), 14'($urandom), 2'($urandom));
      drain();
      chk("stream_stalls", stalls - st0, 0);
      chk("stream_count", pops, pushes);

      // random stalls on both sides
      rnd = 1'b1;
      for (int i = 0; i < 40; i++) begin
         idle($urandom_range(0, 2));
         send(7'($urandom), 7'($urandom), 14'($urandom), 2'($urandom));
      end
      drain();
      rnd = 1'b0;
      out_ready = 1'b1;
      chk("rand_count", pops, pushes);

      // reset mid-stream
      out_ready = 1'b0;
      send(7'd10, 7'd10, 14'd5, 2'b00);
      send(7'd11, 7'd11, 14'd5, 2'b00);
      A = 7'd12; B = 7'd12; C = 14'd5; mode = 2'b00;
      in_valid = 1'b1;
      @(posedge clk_n);
      #2 reset_n = 1'b1;
      #1;
      chk("mid_rst_result", {17'd0, result_s}, 32'd0);
      chk("mid_rst_vld", {31'd0, out_valid_s}, 32'd0);
      chk("mid_rst_ovf_s", {31'd0, overflow_s}, 32'd0);
      chk("mid_rst_ovf_w", {31'd0, overflow_w}, 32'd0);
      in_valid = 1'b0;
      @(posedge clk_n);
      #1 reset_n = 1'b0;
      out_ready = 1'b1;
      idle(5);
      chk("no_stale_beat", {31'd0, out_valid_s}, 32'd0);
      send(7'd2, 7'd3, 14'd0, 2'b01);
      drain();
      idle(1);
      chk("acc_after_reset", {17'd0, result_s}, 32'd6);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
